// File: rtl/nor_pkg.sv
// Shared definitions for the NOR flash bus controller: cycle codes, FSM states,
// command-sequence constants and the per-step bus-op descriptor.
package nor_pkg;

  localparam logic [5:0] CYC_READ         = 6'h01;
  localparam logic [5:0] CYC_WRITE        = 6'h02;
  localparam logic [5:0] CYC_PROGRAM      = 6'h03;
  localparam logic [5:0] CYC_ERASE_SECTOR = 6'h04;
  localparam logic [5:0] CYC_ERASE_CHIP   = 6'h05;
  localparam logic [5:0] CYC_RESET        = 6'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RD_PULSE,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_BSY_DLY,
    ST_BSY_WAIT,
    ST_DONE
  } nor_state_e;

  typedef enum logic [1:0] {
    ADDR_REQ,
    ADDR_555,
    ADDR_2AA,
    ADDR_ZERO
  } addr_sel_e;

  localparam logic [11:0] UNLOCK_ADDR1 = 12'h555;
  localparam logic [11:0] UNLOCK_ADDR2 = 12'h2AA;
  localparam logic [7:0]  UNLOCK_DATA1 = 8'hAA;
  localparam logic [7:0]  UNLOCK_DATA2 = 8'h55;
  localparam logic [7:0]  CMD_PROGRAM  = 8'hA0;
  localparam logic [7:0]  CMD_ERASE    = 8'h80;
  localparam logic [7:0]  CMD_SECTOR   = 8'h30;
  localparam logic [7:0]  CMD_CHIP     = 8'h10;
  localparam logic [7:0]  CMD_RESET    = 8'hF0;

  typedef struct packed {
    addr_sel_e   addr_sel;
    logic        req_data;   // drive latched request data instead of the constant
    logic [7:0]  data;
    logic        rd;
    logic        last;
    logic        busy_wait;
  } seq_op_t;

  function automatic logic code_valid(input logic [5:0] code);
    return (code >= CYC_READ) && (code <= CYC_RESET);
  endfunction

endpackage

// File: rtl/nor_seq_rom.sv
// Combinational command-sequence table: (cycle code, step index) -> bus operation.
module nor_seq_rom
  import nor_pkg::*;
(
  input  logic [5:0] code,
  input  logic [2:0] step,
  output seq_op_t    op
);

  always_comb begin
    op = '{ADDR_555, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    case (code)
      CYC_READ: begin
        op.addr_sel = ADDR_REQ;
        op.rd       = 1'b1;
      end
      CYC_WRITE: begin
        op.addr_sel = ADDR_REQ;
        op.req_data = 1'b1;
      end
      CYC_RESET: begin
        op.addr_sel = ADDR_ZERO;
        op.data     = CMD_RESET;
      end
      CYC_PROGRAM: begin
        op.busy_wait = 1'b1;
        op.last      = (step == 3'd3);
        case (step)
          3'd0:    op.data = UNLOCK_DATA1;
          3'd1: begin
            op.addr_sel = ADDR_2AA;
            op.data     = UNLOCK_DATA2;
          end
          3'd2:    op.data = CMD_PROGRAM;
          default: begin
            op.addr_sel = ADDR_REQ;
            op.req_data = 1'b1;
          end
        endcase
      end
      CYC_ERASE_SECTOR, CYC_ERASE_CHIP: begin
        op.busy_wait = 1'b1;
        op.last      = (code == CYC_ERASE_CHIP) ? (step == 3'd6) : (step == 3'd5);
        case (step)
          3'd0, 3'd3: op.data = UNLOCK_DATA1;
          3'd1, 3'd4: begin
            op.addr_sel = ADDR_2AA;
            op.data     = UNLOCK_DATA2;
          end
          3'd2:    op.data = CMD_ERASE;
          3'd5: begin
            op.addr_sel = ADDR_REQ;
            op.data     = CMD_SECTOR;
          end
          default: op.data = CMD_CHIP;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nor_bus_ctrl.sv
// Wishbone pipelined slave that turns one request into a timed NOR flash
// bus-op sequence (read, write, or unlock/command sequence with busy wait).
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for a request; only state with stall low
// ST_SETUP    | one cycle: ce_n low, address (and write data) set up
// ST_RD_PULSE | oe_n low for T_RD cycles, data captured on the last one
// ST_WR_PULSE | we_n low for T_WP cycles
// ST_WR_HOLD  | we_n high, addr/dq held for T_WH cycles
// ST_BSY_DLY  | T_BSY cycles before RY/BY is trusted
// ST_BSY_WAIT | wait for synchronized ready, bounded by the timeout
// ST_DONE     | one-cycle ack (or err on timeout)
module nor_bus_ctrl
  import nor_pkg::*;
#(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16,
  parameter int T_RD     = 8,
  parameter int T_WP     = 4,
  parameter int T_WH     = 4,
  parameter int T_BSY    = 16,
  parameter int TO_BITS  = 24
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [DATABITS-1:0] wb_dat_i,
  output logic [DATABITS-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_stall_o,
  output logic [ADDRBITS-1:0] nor_addr_o,
  output logic [DATABITS-1:0] nor_dq_o,
  input  logic [DATABITS-1:0] nor_dq_i,
  output logic                nor_dq_oe_o,
  output logic                nor_ce_n_o,
  output logic                nor_oe_n_o,
  output logic                nor_we_n_o,
  input  logic                nor_ryby_i
);

  localparam int TMR_W = 16;
  localparam logic [TO_BITS-1:0] TO_LOAD = {{(TO_BITS-1){1'b1}}, 1'b0};

  nor_state_e          state_q, state_d;
  logic [5:0]          req_code_q;
  logic [ADDRBITS-1:0] req_addr_q;
  logic [DATABITS-1:0] req_data_q;
  logic [DATABITS-1:0] rd_data_q;
  logic [2:0]          step_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [TO_BITS-1:0]  to_cnt_q;
  logic                to_flag_q, abort_q, inv_err_q;
  logic                ryby_meta_q, ryby_sync_q;
  logic                accept, bus_act;
  logic [ADDRBITS-1:0] addr_mux;
  logic [DATABITS-1:0] data_mux;
  seq_op_t             op;
  logic                unused_we;

  // Direction is implied by the cycle code; the WE strobe carries no extra information.
  assign unused_we = wb_we_i;

  nor_seq_rom u_seq_rom (
    .code (req_code_q),
    .step (step_q),
    .op   (op)
  );

  assign accept = wb_cyc_i & wb_stb_i & ~wb_stall_o;

  always_comb begin
    state_d     = state_q;
    wb_stall_o  = (state_q != ST_IDLE);
    nor_ce_n_o  = 1'b1;
    nor_oe_n_o  = 1'b1;
    nor_we_n_o  = 1'b1;
    nor_dq_oe_o = 1'b0;
    case (state_q)
      ST_IDLE:
        if (accept && code_valid(wb_adr_i[31:26])) state_d = ST_SETUP;
      ST_SETUP: begin
        nor_ce_n_o  = 1'b0;
        nor_dq_oe_o = ~op.rd;
        state_d     = op.rd ? ST_RD_PULSE : ST_WR_PULSE;
      end
      ST_RD_PULSE: begin
        nor_ce_n_o = 1'b0;
        nor_oe_n_o = 1'b0;
        if (tmr_q == '0) state_d = ST_DONE;
      end
      ST_WR_PULSE: begin
        nor_ce_n_o  = 1'b0;
        nor_we_n_o  = 1'b0;
        nor_dq_oe_o = 1'b1;
        if (tmr_q == '0) state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        nor_ce_n_o  = 1'b0;
        nor_dq_oe_o = 1'b1;
        if (tmr_q == '0) begin
          if (!op.last)          state_d = ST_SETUP;
          else if (op.busy_wait) state_d = ST_BSY_DLY;
          else                   state_d = ST_DONE;
        end
      end
      ST_BSY_DLY:
        if (tmr_q == '0) state_d = ST_BSY_WAIT;
      ST_BSY_WAIT:
        if (ryby_sync_q || (to_cnt_q == '0)) state_d = ST_DONE;
      ST_DONE:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      req_code_q  <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      rd_data_q   <= '0;
      step_q      <= '0;
      tmr_q       <= '0;
      to_cnt_q    <= '0;
      to_flag_q   <= 1'b0;
      abort_q     <= 1'b0;
      inv_err_q   <= 1'b0;
      ryby_meta_q <= 1'b0;
      ryby_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ryby_meta_q <= nor_ryby_i;
      ryby_sync_q <= ryby_meta_q;
      inv_err_q   <= accept & ~code_valid(wb_adr_i[31:26]);

      if (accept) begin
        req_code_q <= wb_adr_i[31:26];
        req_addr_q <= wb_adr_i[ADDRBITS-1:0];
        req_data_q <= wb_dat_i;
        step_q     <= '0;
        abort_q    <= 1'b0;
        to_flag_q  <= 1'b0;
      end else if (state_q != ST_IDLE && !wb_cyc_i) begin
        // Flash commands cannot be aborted; only the bus response is dropped.
        abort_q <= 1'b1;
      end

      if (state_q == ST_WR_HOLD && state_d == ST_SETUP) step_q <= step_q + 3'd1;

      if (state_d != state_q) begin
        case (state_d)
          ST_RD_PULSE: tmr_q <= TMR_W'(T_RD - 1);
          ST_WR_PULSE: tmr_q <= TMR_W'(T_WP - 1);
          ST_WR_HOLD:  tmr_q <= TMR_W'(T_WH - 1);
          ST_BSY_DLY:  tmr_q <= TMR_W'(T_BSY - 1);
          default:     tmr_q <= '0;
        endcase
      end else if (tmr_q != '0) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end

      if (state_d == ST_BSY_WAIT && state_q != ST_BSY_WAIT) to_cnt_q <= TO_LOAD;
      else if (state_q == ST_BSY_WAIT && to_cnt_q != '0) to_cnt_q <= to_cnt_q - TO_BITS'(1);

      if (state_q == ST_BSY_WAIT && !ryby_sync_q && to_cnt_q == '0) to_flag_q <= 1'b1;

      if (state_q == ST_RD_PULSE && tmr_q == '0) rd_data_q <= nor_dq_i;
    end
  end

  assign bus_act = (state_q == ST_SETUP) || (state_q == ST_RD_PULSE) ||
                   (state_q == ST_WR_PULSE) || (state_q == ST_WR_HOLD);

  always_comb begin
    case (op.addr_sel)
      ADDR_555:  addr_mux = ADDRBITS'(UNLOCK_ADDR1);
      ADDR_2AA:  addr_mux = ADDRBITS'(UNLOCK_ADDR2);
      ADDR_ZERO: addr_mux = '0;
      default:   addr_mux = req_addr_q;
    endcase
    data_mux = op.req_data ? req_data_q : DATABITS'(op.data);
  end

  assign nor_addr_o = bus_act ? addr_mux : '0;
  assign nor_dq_o   = (bus_act && !op.rd) ? data_mux : '0;
  assign wb_dat_o   = rd_data_q;
  assign wb_ack_o   = (state_q == ST_DONE) & ~to_flag_q & ~abort_q & wb_cyc_i;
  assign wb_err_o   = ((state_q == ST_DONE) & to_flag_q & ~abort_q & wb_cyc_i) | inv_err_q;

endmodule

// File: tb/tb_nor_bus_ctrl.sv
// Randomized bench for nor_bus_ctrl: a bus monitor records every NOR write/read
// pulse and compares it against the expected command sequence for each request.
module tb_nor_bus_ctrl;

  localparam int AW = 26, DW = 16, TRD = 8, TWP = 4, TWH = 4, TBSY = 16, TOB = 8;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]   wb_adr_i;
  logic [DW-1:0] wb_dat_i, wb_dat_o;
  logic          wb_ack_o, wb_err_o, wb_stall_o;
  logic [AW-1:0] nor_addr_o;
  logic [DW-1:0] nor_dq_o, nor_dq_i;
  logic          nor_dq_oe_o, nor_ce_n_o, nor_oe_n_o, nor_we_n_o, nor_ryby_i;

  always #5 clk_i = ~clk_i;

  nor_bus_ctrl #(
    .ADDRBITS(AW), .DATABITS(DW), .T_RD(TRD), .T_WP(TWP), .T_WH(TWH),
    .T_BSY(TBSY), .TO_BITS(TOB)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
    .nor_addr_o(nor_addr_o), .nor_dq_o(nor_dq_o), .nor_dq_i(nor_dq_i),
    .nor_dq_oe_o(nor_dq_oe_o), .nor_ce_n_o(nor_ce_n_o), .nor_oe_n_o(nor_oe_n_o),
    .nor_we_n_o(nor_we_n_o), .nor_ryby_i(nor_ryby_i)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash array contents as seen by reads.
  function automatic logic [DW-1:0] flash_val(input logic [AW-1:0] a);
    if (a == 26'h0001234) return 16'hBEEF;
    return 16'h3C5A ^ a[15:0] ^ {6'b0, a[25:16]};
  endfunction

  always_comb nor_dq_i = flash_val(nor_addr_o);

  // Bus monitor
  logic [AW-1:0] mw_a[$];
  logic [DW-1:0] mw_d[$];
  int            mw_len[$], mr_len[$];
  logic [AW-1:0] w_a;
  logic [DW-1:0] w_d;
  int wlen = 0, olen = 0, cyc_no = 0, last_rise = 0, n_ack = 0, n_err = 0;
  int ack_cyc = 0, err_cyc = 0, ce_low = 0, viol = 0;

  always @(negedge clk_i) begin
    cyc_no++;
    if (!nor_we_n_o) begin
      wlen++;
      w_a = nor_addr_o;
      w_d = nor_dq_o;
      if (!nor_dq_oe_o) viol++;
    end else if (wlen != 0) begin
      mw_a.push_back(w_a);
      mw_d.push_back(w_d);
      mw_len.push_back(wlen);
      wlen = 0;
      last_rise = cyc_no;
    end
    if (!nor_oe_n_o) olen++;
    else if (olen != 0) begin
      mr_len.push_back(olen);
      olen = 0;
    end
    if (!nor_oe_n_o && !nor_we_n_o) viol++;
    if (!nor_oe_n_o && nor_dq_oe_o) viol++;
    if (!nor_ce_n_o) ce_low++;
    if (wb_ack_o) begin n_ack++; ack_cyc = cyc_no; end
    if (wb_err_o) begin n_err++; err_cyc = cyc_no; end
  end

  // Reference model: the NOR writes each cycle code should produce.
  logic [AW-1:0] ex_a[$];
  logic [DW-1:0] ex_d[$];
  bit ex_busy, ex_valid, ex_rd;
  logic [DW-1:0] last_rd = '0;

  function automatic void ex_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ex_a.push_back(a);
    ex_d.push_back(d);
  endfunction

  function automatic void ref_seq(input logic [5:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ex_a.delete(); ex_d.delete();
    ex_busy = 0; ex_valid = 1; ex_rd = 0;
    case (c)
      6'h01: ex_rd = 1;
      6'h02: ex_push(a, d);
      6'h06: ex_push(0, 16'h00F0);
      6'h03: begin
        ex_push(26'h555, 16'h00AA); ex_push(26'h2AA, 16'h0055);
        ex_push(26'h555, 16'h00A0); ex_push(a, d);
        ex_busy = 1;
      end
      6'h04, 6'h05: begin
        ex_push(26'h555, 16'h00AA); ex_push(26'h2AA, 16'h0055);
        ex_push(26'h555, 16'h0080); ex_push(26'h555, 16'h00AA);
        ex_push(26'h2AA, 16'h0055); ex_push(a, 16'h0030);
        if (c == 6'h05) ex_push(26'h555, 16'h0010);
        ex_busy = 1;
      end
      default: ex_valid = 0;
    endcase
  endfunction

  // ryby_dly < 0 holds RY/BY low (timeout); drop2 releases cyc during the 2nd write.
  task automatic run_txn(input logic [5:0] code, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int ryby_dly, input bit drop2);
    int acc_cyc, rise_cyc;
    bit done, dropped, exp_ack, exp_err;
    ref_seq(code, a, d);
    @(negedge clk_i); #1;
    mw_a.delete(); mw_d.delete(); mw_len.delete(); mr_len.delete();
    n_ack = 0; n_err = 0; ce_low = 0;
    if (ex_busy) nor_ryby_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = ~ex_rd;
    wb_adr_i = {code, a}; wb_dat_i = d;
    @(posedge clk_i);
    acc_cyc = cyc_no + 1;
    @(negedge clk_i); #1;
    wb_stb_i = 1'b0; wb_adr_i = $urandom; wb_dat_i = DW'($urandom);
    rise_cyc = -1; done = 0; dropped = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (drop2 && !dropped && mw_a.size() == 1 && !nor_we_n_o) begin
        wb_cyc_i = 1'b0;
        dropped = 1;
      end
      if (ex_busy && rise_cyc < 0 && ryby_dly >= 0 && mw_a.size() == ex_a.size() &&
          cyc_no - last_rise >= ryby_dly) begin
        nor_ryby_i = 1'b1;
        rise_cyc = cyc_no;
      end
      if (n_ack + n_err > 0 || (dropped && !wb_stall_o)) done = 1;
      else begin
        @(negedge clk_i); #1;
      end
    end
    chk("txn_done", 32'(done), 1);
    chk("n_writes", mw_a.size(), ex_a.size());
    for (int i = 0; i < mw_a.size() && i < ex_a.size(); i++) begin
      chk("wr_addr", mw_a[i], ex_a[i]);
      chk("wr_data", mw_d[i], ex_d[i]);
      chk("we_len", mw_len[i], TWP);
    end
    chk("n_reads", mr_len.size(), ex_rd ? 1 : 0);
    if (ex_rd) begin
      if (mr_len.size() > 0) chk("oe_len", mr_len[0], TRD);
      last_rd = flash_val(a);
    end
    chk("dat_o", wb_dat_o, last_rd);
    exp_ack = ex_valid && !drop2 && !(ex_busy && ryby_dly < 0);
    exp_err = !drop2 && (!ex_valid || (ex_busy && ryby_dly < 0));
    chk("ack_cnt", n_ack, 32'(exp_ack));
    chk("err_cnt", n_err, 32'(exp_err));
    if (!ex_valid) begin
      chk("inv_err_cyc", err_cyc, acc_cyc);
      chk("inv_ce_low", ce_low, 0);
    end
    if (ex_busy && ryby_dly >= 0 && !drop2) chk("ryby_lat", ack_cyc - rise_cyc, 3);
    if (ex_busy && ryby_dly < 0) chk("to_len", err_cyc - last_rise, TWH + TBSY + (2**TOB - 1));
    wb_cyc_i = 1'b0;
    nor_ryby_i = 1'b1;
  endtask

  initial begin
    logic [5:0] c;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0;
    nor_ryby_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_ce", nor_ce_n_o, 1);
    chk("rst_oe", nor_oe_n_o, 1);
    chk("rst_we", nor_we_n_o, 1);
    chk("rst_dq_oe", nor_dq_oe_o, 0);
    chk("rst_addr", nor_addr_o, 0);
    chk("rst_dq", nor_dq_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_resp", {wb_ack_o, wb_err_o, wb_stall_o}, 0);
    reset_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    run_txn(6'h01, 26'h0001234, 16'h0, 0, 0);
    run_txn(6'h03, 26'h0000010, 16'h5A5A, 100, 0);
    run_txn(6'h05, 26'(($urandom)), 16'h0, -1, 0);
    run_txn(6'h3F, 26'h0000123, 16'h1111, 0, 0);
    run_txn(6'h04, 26'h0ABCDE0, 16'h0, 30, 1);
    run_txn(6'h01, 26'h0000777, 16'h0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 6))
        0: c = 6'h01;
        1: c = 6'h02;
        2: c = 6'h03;
        3: c = 6'h04;
        4: c = 6'h05;
        5: c = 6'h06;
        default: c = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom_range(7, 63));
      endcase
      run_txn(c, 26'($urandom), 16'($urandom), int'($urandom_range(20, 150)), 0);
    end

    // Reset in the middle of a program write pulse
    @(negedge clk_i); #1;
    nor_ryby_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = {6'h03, 26'h0002000}; wb_dat_i = 16'hC0DE;
    @(negedge clk_i); #1;
    wb_stb_i = 1'b0;
    for (int i = 0; i < 100 && nor_we_n_o; i++) begin
      @(negedge clk_i); #1;
    end
    chk("rst_mid_reach_wp", nor_we_n_o, 0);
    #2 reset_ni = 1'b0;
    #1;
    chk("rst_mid_we", nor_we_n_o, 1);
    chk("rst_mid_ce", nor_ce_n_o, 1);
    chk("rst_mid_dq_oe", nor_dq_oe_o, 0);
    chk("rst_mid_stall", wb_stall_o, 0);
    @(negedge clk_i); #1;
    reset_ni = 1'b1; wb_cyc_i = 1'b0; nor_ryby_i = 1'b1;
    last_rd = '0;
    chk("rst_mid_dat", wb_dat_o, 0);
    repeat (3) @(negedge clk_i);
    run_txn(6'h01, 26'h0003456, 16'h0, 0, 0);
    run_txn(6'h02, 26'h0003456, 16'hA5A5, 0, 0);

    chk("bus_excl", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nor_bus_ctrl.md
NOR_BUS_CTRL -- requirements
Module: nor_bus_ctrl

Interface
REQ-001 Parameter ADDRBITS, 26, NOR word-address width.
REQ-002 Parameter DATABITS, 16, NOR data width.
REQ-003 Parameters T_RD 8, T_WP 4, T_WH 4: read access, write pulse and write recovery times, in clk_i cycles.
REQ-004 Parameter T_BSY, 16, cycles to wait after the final command write before sampling RY/BY.
REQ-005 Parameter TO_BITS, 24, busy-timeout counter width; timeout = 2^TO_BITS-1 cycles.
REQ-006 clk_i  in  1  system clock; one clock only, all logic on its rising edge.
REQ-007 reset_ni  in  1  reset, asynchronous assert, active-low.
REQ-008 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone pipelined slave controls.
REQ-009 wb_adr_i  in  32  [31:26] NOR cycle code, [ADDRBITS-1:0] word address.
REQ-010 wb_dat_i  in  DATABITS  write data; wb_dat_o  out  DATABITS  read data.
REQ-011 wb_ack_o, wb_err_o, wb_stall_o  out  1 each  Wishbone responses.
REQ-012 nor_addr_o  out  ADDRBITS  NOR address; nor_dq_o  out  DATABITS; nor_dq_i  in  DATABITS; nor_dq_oe_o  out  1  drive enable.
REQ-013 nor_ce_n_o, nor_oe_n_o, nor_we_n_o  out  1 each  active-low NOR strobes; nor_ryby_i  in  1  async ready/busy, 1 = ready.

Function
REQ-014 Cycle codes: READ 6'h01, WRITE 6'h02, PROGRAM 6'h03, ERASE_SECTOR 6'h04, ERASE_CHIP 6'h05, RESET 6'h06; any other code is invalid.
REQ-015 Request accepted when wb_cyc_i & wb_stb_i & !wb_stall_o; adr, dat and we latched that cycle.
REQ-016 wb_stall_o high in every state except IDLE.
REQ-017 Bus-op sequences (addr/data): READ = one read at A; WRITE = one write A/D; RESET = write 0/F0; PROGRAM = 555/AA, 2AA/55, 555/A0, A/D, then busy-wait; ERASE_SECTOR = 555/AA, 2AA/55, 555/80, 555/AA, 2AA/55, A/30, then busy-wait; ERASE_CHIP = same as ERASE_SECTOR with a final 555/10, then busy-wait.
REQ-018 States: IDLE, SETUP, RD_PULSE, WR_PULSE, WR_HOLD, BSY_DLY, BSY_WAIT, DONE.
REQ-019 SETUP lasts 1 cycle: ce_n=0, addr valid; for a write, dq_oe=1 and dq valid.
REQ-020 RD_PULSE: oe_n=0 for exactly T_RD cycles; nor_dq_i captured into wb_dat_o on the last cycle; then DONE.
REQ-021 WR_PULSE: we_n=0 for exactly T_WP cycles; WR_HOLD: we_n=1 with addr/dq held for T_WH cycles; then next op -> SETUP, or last op -> BSY_DLY if busy-wait, else DONE.
REQ-022 BSY_DLY counts T_BSY cycles; BSY_WAIT exits to DONE when the synchronized ryby is 1.
REQ-023 nor_ryby_i passes through a 2-flop synchronizer before use.
REQ-024 BSY_WAIT longer than 2^TO_BITS-1 cycles -> DONE with error flag set.
REQ-025 DONE (1 cycle): pulse wb_ack_o, or wb_err_o if timed out; ce_n=1, dq_oe=0; -> IDLE.
REQ-026 Invalid code: wb_err_o pulses the cycle after acceptance; no NOR strobe asserted; stays IDLE.
REQ-027 wb_cyc_i dropped mid-sequence: sequence still runs to completion (flash commands are not abortable); ack/err suppressed.
REQ-028 oe_n and we_n are never low simultaneously; dq_oe=0 whenever oe_n=0.
REQ-029 wb_dat_o holds the last read value until the next READ completes.

Reset
REQ-030 While reset_ni=0: state IDLE, ce_n/oe_n/we_n = 1, dq_oe = 0, addr/dq/wb_dat_o = 0, ack/err = 0, stall = 0, all counters = 0.
REQ-031 Reset asserted mid-operation releases the NOR bus immediately (asynchronously); the interrupted sequence is not resumed.

Structure
REQ-032 Package nor_pkg holds: cycle codes, state encoding, unlock constants (555, 2AA, AA, 55, A0, 80, 30, 10, F0).
REQ-033 Sub-module nor_seq_rom: combinational (cycle code, step index) -> {addr_sel, data, last, busy_wait}.

Verification
REQ-034 READ at 0x0001234, NOR model returns 0xBEEF -> oe_n low for exactly 8 cycles; ack once; wb_dat_o = 0xBEEF.
REQ-035 PROGRAM at 0x10 with data 0x5A5A, ryby low for 100 cycles -> four writes in order 555/AA, 2AA/55, 555/A0, 10/5A5A, each we_n low 4 cycles; ack after ryby high + 2 sync cycles.
REQ-036 ERASE_CHIP, ryby held low, TO_BITS=8 -> err pulse after 255 BSY_WAIT cycles; no ack.
REQ-037 Code 6'h3F -> err the next cycle; ce_n stays 1 throughout.
REQ-038 Drop wb_cyc_i during the 2nd ERASE_SECTOR write -> all 6 writes complete; no ack/err; the next request is accepted normally.
REQ-039 Assert reset_ni low during WR_PULSE -> we_n=1, ce_n=1, dq_oe=0 within the same cycle; state IDLE after release.
